// File: rtl/proc_feeder_pkg.sv
// proc_feeder_pkg: state encoding, opcodes and decode helper shared by the instruction feeder
package proc_feeder_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        IMM,
        WAIT_DONE,
        HALTED,
        ERROR
`ifdef FEEDER_SINGLE_STEP_EN
        , STEP_WAIT
`endif
    } state_t;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_HALT = 3'b111;

    function automatic logic is_two_word(input logic [2:0] opcode, input logic [2:0] mvi_op);
        return opcode == mvi_op;
    endfunction

endpackage

// File: rtl/proc_instr_feeder_if.sv
// proc_instr_feeder_if: loader, start/done handshake and status bundle (Step exists with FEEDER_SINGLE_STEP_EN)
interface proc_instr_feeder_if #(parameter int AW = 5);

    logic          Load_we;
    logic [AW-1:0] Load_addr;
    logic [8:0]    Load_data;
    logic          Start;
    logic          Done;
`ifdef FEEDER_SINGLE_STEP_EN
    logic          Step;
`endif
    logic [8:0]    DIN;
    logic          Run;
    logic          Busy;
    logic          Halted;
    logic          Error;
    logic [AW-1:0] PC;
    logic [7:0]    InstrCount;

    modport master (
        input  Load_we, Load_addr, Load_data, Start, Done,
`ifdef FEEDER_SINGLE_STEP_EN
        input  Step,
`endif
        output DIN, Run, Busy, Halted, Error, PC, InstrCount
    );

    modport slave (
        output Load_we, Load_addr, Load_data, Start, Done,
`ifdef FEEDER_SINGLE_STEP_EN
        output Step,
`endif
        input  DIN, Run, Busy, Halted, Error, PC, InstrCount
    );

endinterface

// File: rtl/feeder_prog_mem.sv
// feeder_prog_mem: DEPTH x 9 program RAM, synchronous write, registered read with enable
module feeder_prog_mem #(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [8:0]    wr_data,
    input  logic          re,
    input  logic [AW-1:0] rd_addr,
    output logic [8:0]    rd_data
);

    logic [8:0] mem [DEPTH];

    // write port and registered read port; rd_data holds while re is low
    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
        if (re) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/proc_instr_feeder.sv
// proc_instr_feeder: plays a stored program into the processor via Run/Done with a watchdog; FEEDER_SINGLE_STEP_EN adds Step gating
module proc_instr_feeder
    import proc_feeder_pkg::*;
#(
    parameter int         DEPTH   = 32,
    parameter int         AW      = $clog2(DEPTH),
    parameter int         TIMEOUT = 15,
    parameter logic [2:0] MVI_OP  = OP_MVI,
    parameter logic [2:0] HALT_OP = OP_HALT
) (
    input logic Clock,
    input logic Reset,
    proc_instr_feeder_if.master bus
);

    localparam int WW = $clog2(TIMEOUT + 1);

`ifdef FEEDER_SINGLE_STEP_EN
    localparam state_t AFTER_DONE = STEP_WAIT;
`else
    localparam state_t AFTER_DONE = FETCH;
`endif

    state_t        state, nxt;
    logic [AW-1:0] pc;
    logic [7:0]    cnt;
    logic [WW-1:0] wd;
    logic [8:0]    din_q;
    logic [8:0]    rd_data;
    logic [AW-1:0] rd_addr;
    logic          re, we, run, busy, launch, waiting, fresh;

    wire [2:0] op      = rd_data[8:6];
    wire       is_halt = op == HALT_OP;
    wire       two     = is_two_word(op, MVI_OP);
    // the watchdog holds the cycle count since Run, so this fires TIMEOUT cycles after Run
    wire       expired = wd == WW'(TIMEOUT - 1);

    feeder_prog_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk     (Clock),
        .we      (we),
        .wr_addr (bus.Load_addr),
        .wr_data (bus.Load_data),
        .re      (re),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // state register
    always_ff @(posedge Clock) state <= Reset ? IDLE : nxt;

    // next-state logic; Done is only looked at in the states after Run
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE, HALTED, ERROR: nxt = bus.Start ? FETCH : state;
            FETCH:               nxt = ISSUE;
            ISSUE:               nxt = is_halt ? HALTED : two ? IMM : WAIT_DONE;
            IMM, WAIT_DONE:      nxt = bus.Done ? AFTER_DONE : expired ? ERROR : WAIT_DONE;
`ifdef FEEDER_SINGLE_STEP_EN
            STEP_WAIT:           nxt = bus.Step ? FETCH : STEP_WAIT;
`endif
            default:             nxt = IDLE;
        endcase
    end

    // outputs and memory controls decoded from the current state
    always_comb begin
        busy           = !(state inside {IDLE, HALTED, ERROR});
        launch         = bus.Start && !busy;
        waiting        = state inside {IMM, WAIT_DONE};
        run            = state == ISSUE && !is_halt;
        fresh          = run || state == IMM;
        re             = state == FETCH || (run && two);
        rd_addr        = state == FETCH ? pc : pc + 1'b1;
        we             = bus.Load_we && state == IDLE;
        bus.Run        = run;
        bus.DIN        = fresh ? rd_data : din_q;
        bus.Busy       = busy;
        bus.Halted     = state == HALTED;
        bus.Error      = state == ERROR;
        bus.PC         = pc;
        bus.InstrCount = cnt;
    end

    // PC, instruction counter, watchdog and held DIN word
    always_ff @(posedge Clock) begin
        if (Reset) begin
            pc    <= '0;
            cnt   <= '0;
            wd    <= '0;
            din_q <= '0;
        end else begin
            if (launch) begin
                pc  <= '0;
                cnt <= '0;
            end
            if (state == ISSUE) wd <= WW'(1);
            else if (waiting) wd <= wd + WW'(1);
            if (run && two) pc <= pc + 1'b1;
            if (waiting && bus.Done) begin
                pc  <= pc + 1'b1;
                cnt <= (cnt == 8'hFF) ? cnt : cnt + 8'd1;
            end
            if (fresh) din_q <= rd_data;
        end
    end

endmodule

// File: tb/tb_proc_instr_feeder.sv
// tb_proc_instr_feeder: directed program runs against the feeder with a latency-programmable Done responder
module tb_proc_instr_feeder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    proc_instr_feeder_if #(.AW(5)) bus();

    proc_instr_feeder dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus.master)
    );

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         lat = 0;
    int         dly = 0;
    int         runs = 0;
    int         run_at = 0;
    logic       prev_run = 1'b0;
    logic       prev_busy = 1'b0;
    logic [4:0] prev_pc = '0;
    logic       wrapped = 1'b0;
    logic [8:0] din_after = '0;
    logic [8:0] run_din = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        bus.Done = 1'b0;
        if (dly > 0) begin
            dly--;
            if (dly == 0) bus.Done = 1'b1;
        end
        if (prev_run) din_after = bus.DIN;
        prev_run = bus.Run;
        if (bus.Run) begin
            runs++;
            run_at  = cyc;
            run_din = bus.DIN;
            if (lat > 0) dly = lat;
        end
        if (prev_pc == 5'd31 && bus.PC == 5'd0) wrapped = 1'b1;
        prev_pc = bus.PC;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        dly = 0;
        bus.Done = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic load(input logic [4:0] a, input logic [8:0] d);
        bus.Load_we   = 1'b1;
        bus.Load_addr = a;
        bus.Load_data = d;
        tick();
        bus.Load_we = 1'b0;
    endtask

    task automatic start();
        runs = 0;
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
    endtask

    task automatic run_until_stop(input int limit);
        for (int i = 0; i < limit && !bus.Halted && !bus.Error; i++) begin
            prev_busy = bus.Busy;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        bus.Load_we   = 1'b0;
        bus.Load_addr = '0;
        bus.Load_data = '0;
        bus.Start     = 1'b0;
        bus.Done      = 1'b0;
`ifdef FEEDER_SINGLE_STEP_EN
        bus.Step      = 1'b0;
`endif
        tick();
        do_reset();
        check("rst busy", bus.Busy, 0);
        check("rst run", bus.Run, 0);
        check("rst pc", bus.PC, 0);
        check("rst cnt", bus.InstrCount, 0);
        check("rst din", bus.DIN, 0);
        check("rst flags", {bus.Halted, bus.Error}, 0);

        // mvi R0, #5 ; halt
        load(5'd0, 9'h040);
        load(5'd1, 9'h005);
        load(5'd2, 9'h1C0);
        lat = 2;
        start();
        run_until_stop(100);
        check("mvi runs", runs, 1);
        check("mvi din run", run_din, 9'h040);
        check("mvi din imm", din_after, 9'h005);
        check("mvi halted", bus.Halted, 1);
        check("mvi cnt", bus.InstrCount, 1);
        check("mvi pc", bus.PC, 2);

        // from HALTED, loads are dropped, so return to IDLE first
        do_reset();
        load(5'd0, 9'h00A);
        load(5'd1, 9'h081);
        load(5'd2, 9'h0C1);
        load(5'd3, 9'h1C0);
        lat = 3;
        start();
        run_until_stop(200);
        check("alu runs", runs, 3);
        check("alu cnt", bus.InstrCount, 3);
        check("alu halted", bus.Halted, 1);
        check("alu busy prev", prev_busy, 1);
        check("alu busy now", bus.Busy, 0);
        check("alu din hold", bus.DIN, 9'h0C1);
        check("alu pc", bus.PC, 3);

        // no Done ever: watchdog
        lat = 0;
        start();
        run_until_stop(100);
        check("wd error", bus.Error, 1);
        check("wd delay", cyc - run_at, 15);
        check("wd pc", bus.PC, 0);
        check("wd run", bus.Run, 0);
        check("wd busy", bus.Busy, 0);
        check("wd cnt", bus.InstrCount, 0);
        lat = 3;
        start();
        run_until_stop(200);
        check("rerun halted", bus.Halted, 1);
        check("rerun cnt", bus.InstrCount, 3);

        // 32 x mv, no halt: PC wraps
        do_reset();
        for (int i = 0; i < 32; i++) load(5'(i), 9'h00A);
        lat = 1;
        wrapped = 1'b0;
        start();
        for (int i = 0; i < 400 && bus.InstrCount != 8'd40; i++) tick();
        check("wrap cnt", bus.InstrCount, 40);
        check("wrap pc", bus.PC, 8);
        check("wrap seen", wrapped, 1);
        check("wrap no halt", bus.Halted, 0);

        // reset while waiting for Done, with a write attempt while busy
        do_reset();
        lat = 0;
        start();
        for (int i = 0; i < 10 && !bus.Run; i++) tick();
        tick();
        check("mid busy", bus.Busy, 1);
        load(5'd1, 9'h1C0);
        do_reset();
        check("mid run", bus.Run, 0);
        check("mid busy rst", bus.Busy, 0);
        check("mid pc", bus.PC, 0);
        lat = 1;
        start();
        for (int i = 0; i < 50 && bus.InstrCount != 8'd2; i++) tick();
        check("readback cnt", bus.InstrCount, 2);
        check("readback halt", bus.Halted, 0);
        check("readback din", run_din, 9'h00A);

`ifdef FEEDER_SINGLE_STEP_EN
        do_reset();
        load(5'd0, 9'h00A);
        load(5'd1, 9'h081);
        load(5'd2, 9'h1C0);
        lat = 1;
        start();
        for (int i = 0; i < 50 && bus.InstrCount != 8'd1; i++) tick();
        repeat (20) tick();
        check("step stall runs", runs, 1);
        check("step stall busy", bus.Busy, 1);
        bus.Step = 1'b1;
        tick();
        bus.Step = 1'b0;
        check("step run early", bus.Run, 0);
        tick();
        check("step run", bus.Run, 1);
        check("step din", bus.DIN, 9'h081);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
